// File: rtl/arp_reply_tx_if.sv
// Request/stream bundle between the ARP parser, the reply transmitter and
// the tx DDIO stage. The requester drives the request fields, the
// transmitter drives the byte stream and status pulses.
interface arp_reply_tx_if;
  logic        i_req;
  logic [47:0] i_SHA;
  logic [31:0] i_SPA;
  logic [7:0]  o_data;
  logic        o_tx_en;
  logic        o_busy;
  logic        o_done;
  logic        o_drop;

  modport master (
    output i_req, i_SHA, i_SPA,
    input  o_data, o_tx_en, o_busy, o_done, o_drop
  );

  modport slave (
    input  i_req, i_SHA, i_SPA,
    output o_data, o_tx_en, o_busy, o_done, o_drop
  );
endinterface

// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: turns one accepted request into a complete
// Ethernet frame (preamble, SFD, 60-byte body, FCS) followed by an IFG.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_req; outputs idle
// S_PRE   | preamble bytes 0x55, last index carries SFD 0xD5
// S_FRAME | 60 body bytes, CRC folded in on every byte
// S_FCS   | four complemented CRC bytes, least significant first
// S_IFG   | tx_en low for IFG_CYCLES; o_done on the last one
//
// cnt_q is the index of the byte currently on o_data within its state.
// The outputs hold the current byte, so the next-state logic always
// prepares the byte for the following cycle.
module arp_reply_tx #(
  parameter logic [47:0] SELF_MAC     = 48'h0023543C471B,
  parameter logic [31:0] SELF_IP      = 32'h0A000021,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          IFG_CYCLES   = 12
) (
  input logic           clk,
  input logic           rst,
  arp_reply_tx_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_FCS, S_IFG} state_t;

  localparam logic [5:0] SFD_IDX    = 6'(PREAMBLE_LEN);
  localparam logic [5:0] FRAME_LAST = 6'd59;
  localparam logic [5:0] FCS_LAST   = 6'd3;
  localparam logic [5:0] IFG_LAST   = 6'(IFG_CYCLES - 1);
  localparam logic [5:0] HDR_BYTES  = 6'd42;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [47:0]   sha_q, sha_d;
  logic [31:0]   spa_q, spa_d;
  logic [7:0]    data_q, data_d;
  logic          tx_en_q, tx_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic [335:0]  hdr;
  logic [335:0]  hdr_sh;
  logic [5:0]    fb_idx;
  logic [7:0]    frame_byte;
  logic [31:0]   crc_next;
  logic [1:0]    fcs_sel;

  // Reflected IEEE 802.3 CRC, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Next-state, next-byte and CRC computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    sha_d   = sha_q;
    spa_d   = spa_q;
    data_d  = data_q;
    tx_en_d = tx_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = bus.i_req && (state_q != S_IDLE);

    // Non-zero part of the body; bytes 42..59 are padding.
    hdr = {sha_q, SELF_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
           16'h0002, SELF_MAC, SELF_IP, sha_q, spa_q};
    fb_idx     = (state_q == S_FRAME) ? (cnt_q + 6'd1) : 6'd0;
    hdr_sh     = hdr << {fb_idx, 3'b000};
    frame_byte = (fb_idx < HDR_BYTES) ? hdr_sh[335:328] : 8'h00;
    crc_next   = crc32_byte(crc_q, data_q);
    fcs_sel    = cnt_q[1:0] + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          state_d = S_PRE;
          cnt_d   = 6'd0;
          crc_d   = 32'hFFFFFFFF;
          sha_d   = bus.i_SHA;
          spa_d   = bus.i_SPA;
          data_d  = 8'h55;
          tx_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == SFD_IDX) begin
          state_d = S_FRAME;
          cnt_d   = 6'd0;
          data_d  = frame_byte;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          data_d = ((cnt_q + 6'd1) == SFD_IDX) ? 8'hD5 : 8'h55;
        end
      end
      S_FRAME: begin
        crc_d = crc_next;
        if (cnt_q == FRAME_LAST) begin
          // Final CRC is used directly so FCS follows without a bubble.
          state_d = S_FCS;
          cnt_d   = 6'd0;
          data_d  = ~crc_next[7:0];
        end else begin
          cnt_d  = cnt_q + 6'd1;
          data_d = frame_byte;
        end
      end
      S_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = S_IFG;
          cnt_d   = 6'd0;
          data_d  = 8'h00;
          tx_en_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          data_d = ~crc_q[{fcs_sel, 3'b000} +: 8];
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          done_d = ((cnt_q + 6'd1) == IFG_LAST);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        data_d  = 8'h00;
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, CRC, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      crc_q   <= 32'hFFFFFFFF;
      sha_q   <= 48'h0;
      spa_q   <= 32'h0;
      data_q  <= 8'h00;
      tx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      sha_q   <= sha_d;
      spa_q   <= spa_d;
      data_q  <= data_d;
      tx_en_q <= tx_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_tx_en = tx_en_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_drop  = drop_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx. Expected frame bytes are generated by a
// field-by-field model and queued when a request is issued; a negedge
// monitor pops and compares every byte seen with o_tx_en high.
module tb_arp_reply_tx;

  localparam logic [47:0] MAC = 48'h0023543C471B;
  localparam logic [31:0] IP  = 32'h0A000021;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  arp_reply_tx_if bus ();
  arp_reply_tx dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  int          cyc = 0;
  logic        prev_en = 1'b0;
  int          idx = 0;
  int          frames = 0;
  int          last_len = 0;
  int          drop_cnt = 0;
  logic [31:0] res = 32'h0;
  logic [31:0] last_res = 32'h0;
  logic [8:0]  sb_exp;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0]  d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [47:0] sha, input logic [31:0] spa);
    logic [7:0]  f[60];
    logic [31:0] c;
    logic [47:0] mac;
    logic [31:0] ip;
    mac = MAC;
    ip  = IP;
    for (int i = 0; i < 60; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      f[i]      = sha[47-8*i -: 8];
      f[6 + i]  = mac[47-8*i -: 8];
      f[22 + i] = mac[47-8*i -: 8];
      f[32 + i] = sha[47-8*i -: 8];
    end
    f[12] = 8'h08; f[13] = 8'h06; f[14] = 8'h00; f[15] = 8'h01;
    f[16] = 8'h08; f[17] = 8'h00; f[18] = 8'h06; f[19] = 8'h04;
    f[20] = 8'h00; f[21] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      f[28 + i] = ip[31-8*i -: 8];
      f[38 + i] = spa[31-8*i -: 8];
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      exp_q.push_back(f[i]);
      c = crc_upd(c, f[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte scoreboard, frame length, FCS residue and pulse counting.
  always @(negedge clk) begin
    if (bus.o_drop === 1'b1) drop_cnt++;
    if (bus.o_tx_en === 1'b1) begin
      if (!prev_en) begin
        idx = 0;
        res = 32'hFFFFFFFF;
        start_q.push_back(cyc);
      end
      if (exp_q.size() > 0) sb_exp = {1'b1, exp_q.pop_front()};
      else                  sb_exp = 9'h000;
      chk("frame_byte", {55'd0, 1'b1, bus.o_data}, {55'd0, sb_exp});
      if (idx >= 8) res = crc_upd(res, bus.o_data);
      idx++;
    end else if (prev_en) begin
      last_len = idx;
      last_res = res;
      frames++;
    end
    prev_en = bus.o_tx_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   f0;
    int   d0;
    int   gap;
    logic seen;

    bus.i_req = 1'b0;
    bus.i_SHA = 48'h0;
    bus.i_SPA = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_data",  bus.o_data, 8'h00);
    chk("rst_tx_en", bus.o_tx_en, 1'b0);
    chk("rst_busy",  bus.o_busy, 1'b0);
    chk("rst_done",  bus.o_done, 1'b0);
    chk("rst_drop",  bus.o_drop, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Reference frame, latency and cycle accounting.
    push_frame(48'h0C54A5312485, 32'h0A000002);
    bus.i_SHA = 48'h0C54A5312485;
    bus.i_SPA = 32'h0A000002;
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("lat_busy",  bus.o_busy, 1'b1);
    chk("lat_tx_en", bus.o_tx_en, 1'b1);
    chk("lat_data",  bus.o_data, 8'h55);
    k = 0;
    while (bus.o_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_cycle", k, 83);
    chk("done_busy", bus.o_busy, 1'b1);
    @(negedge clk);
    chk("busy_after_done", bus.o_busy, 1'b0);
    chk("done_width", bus.o_done, 1'b0);
    chk("tx_en_len", last_len, 72);
    chk("fcs_residue", last_res, 32'hDEBB20E3);
    chk("sb_empty1", exp_q.size(), 0);
    chk("frames1", frames, 1);

    // Requests while busy are dropped and do not disturb the frame.
    f0 = frames;
    d0 = drop_cnt;
    push_frame(48'hFFEEDDCCBBAA, 32'hC0A80105);
    bus.i_SHA = 48'hFFEEDDCCBBAA;
    bus.i_SPA = 32'hC0A80105;
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    bus.i_SHA = 48'hDEADBEEF0001;
    bus.i_SPA = 32'h12345678;
    repeat (28) @(negedge clk);
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("drop_frame", bus.o_drop, 1'b1);
    @(negedge clk);
    chk("drop_frame_end", bus.o_drop, 1'b0);
    repeat (48) @(negedge clk);
    chk("in_ifg", {bus.o_tx_en, bus.o_busy}, 2'b01);
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("drop_ifg", bus.o_drop, 1'b1);
    k = 0;
    while (bus.o_busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (100) @(negedge clk);
    chk("idle2", bus.o_busy, 1'b0);
    chk("drop_count2", drop_cnt - d0, 2);
    chk("no_second_frame", frames - f0, 1);
    chk("sb_empty2", exp_q.size(), 0);
    chk("fcs_residue2", last_res, 32'hDEBB20E3);

    // Request held high: two frames 85 cycles apart, drops on busy cycles.
    f0 = frames;
    d0 = drop_cnt;
    start_q.delete();
    push_frame(48'h001122334455, 32'h0A0000FE);
    push_frame(48'h001122334455, 32'h0A0000FE);
    bus.i_SHA = 48'h001122334455;
    bus.i_SPA = 32'h0A0000FE;
    bus.i_req = 1'b1;
    repeat (150) @(negedge clk);
    bus.i_req = 1'b0;
    repeat (100) @(negedge clk);
    gap = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : 0;
    chk("held_frames", frames - f0, 2);
    chk("held_starts", start_q.size(), 2);
    chk("held_gap", gap, 85);
    chk("held_drops", drop_cnt - d0, 148);
    chk("sb_empty3", exp_q.size(), 0);
    chk("idle3", bus.o_busy, 1'b0);

    // Reset in the middle of a frame.
    push_frame(48'h0A0B0C0D0E0F, 32'h0A000003);
    bus.i_SHA = 48'h0A0B0C0D0E0F;
    bus.i_SPA = 32'h0A000003;
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    repeat (38) @(negedge clk);
    chk("pre_rst_tx_en", bus.o_tx_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_tx_en", bus.o_tx_en, 1'b0);
    chk("rst_async_busy",  bus.o_busy, 1'b0);
    chk("rst_async_data",  bus.o_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_tx_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_data !== 8'h00)
        seen = 1'b1;
    end
    chk("idle_after_rst", seen, 1'b0);

    f0 = frames;
    push_frame(48'h665544332211, 32'h0A000004);
    bus.i_SHA = 48'h665544332211;
    bus.i_SPA = 32'h0A000004;
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    k = 0;
    while (bus.o_busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("post_rst_idle", bus.o_busy, 1'b0);
    chk("post_rst_frames", frames - f0, 1);
    chk("post_rst_len", last_len, 72);
    chk("post_rst_residue", last_res, 32'hDEBB20E3);
    chk("sb_empty4", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
